// File: rtl/reg_fifo_pkg.sv
// Shared constants and helpers for the register-output capture FIFO.
// Sizing functions are usable in constant (parameter/port-width) context.
package reg_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer advance with explicit wrap, so DEPTH need not be a power of two.
  function automatic int ptr_inc(input int ptr, input int depth);
    int nxt;
    if (ptr == depth - 1) begin
      nxt = 0;
    end else begin
      nxt = ptr + 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/reg_fifo_mem.sv
// WIDTH x DEPTH storage: synchronous write port, asynchronous read port.
// Contents are intentionally not reset.
module reg_fifo_mem
  import reg_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/reg_out_fifo.sv
// Captures each newly loaded register-stage value one cycle after its enable
// and streams it out of a first-word-fall-through FIFO with sticky overflow.
module reg_out_fifo
  import reg_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          outa,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  input  logic                      ovf_clr
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic          enable_d_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  logic             push_req_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic [CW-1:0]    count_nx_s;
  logic             overflow_nx_s;
  logic [PW-1:0]    wr_ptr_nx_s;
  logic [PW-1:0]    rd_ptr_nx_s;
  logic [WIDTH-1:0] rdata_s;

  // outa carries the freshly loaded value in the cycle after enable.
  assign push_req_s  = enable_d_r;
  assign full_s      = (count_r == CW'(DEPTH));
  assign out_valid   = (count_r != {CW{1'b0}});
  assign pop_s       = out_valid & out_ready;
  assign push_s      = push_req_s & (~full_s | pop_s);
  assign drop_s      = push_req_s & full_s & ~pop_s;
  assign wr_ptr_nx_s = PW'(ptr_inc(int'(wr_ptr_r), DEPTH));
  assign rd_ptr_nx_s = PW'(ptr_inc(int'(rd_ptr_r), DEPTH));

  // Occupancy and sticky-overflow next-state; a drop beats a same-cycle clear.
  always_comb begin
    count_nx_s    = count_r;
    overflow_nx_s = overflow_r;
    case ({push_s, pop_s})
      2'b10:   count_nx_s = count_r + CW'(1);
      2'b01:   count_nx_s = count_r - CW'(1);
      default: count_nx_s = count_r;
    endcase
    if (drop_s) begin
      overflow_nx_s = 1'b1;
    end else if (ovf_clr) begin
      overflow_nx_s = 1'b0;
    end else begin
      overflow_nx_s = overflow_r;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_d_r <= 1'b0;
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      enable_d_r <= enable;
      count_r    <= count_nx_s;
      overflow_r <= overflow_nx_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_nx_s;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_nx_s;
      end
    end
  end

  reg_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (outa),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  assign out_data = out_valid ? rdata_s : {WIDTH{1'b0}};
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule
